mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port word memory between the instruction-fetch unit (read-only port I) and the load/store unit (read/write port D). It grants one request per cycle with round-robin fairness and registers the chosen command onto the memory's mode/address/data inputs. It routes the memory's read data back to the requester that issued it, and keeps a saturating count of contention cycles for bring-up. It sits between the processor core and the `memory` instance, and is the only driver of the memory's inputs.

---
 rtl/mem_arbiter.sv | 74 +++++++
 tb/tb_mem_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port word memory between
// the fetch port (I, read-only) and the load/store port (D).
module mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic [1:0]  mem_mode,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] conflict_cnt
);
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_OUT  = 2'b01;
    localparam logic [1:0] MODE_IN   = 2'b10;
    logic        last_d_q, last_d_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, cnt_q, cnt_d;
    logic        tag_q, tag_d, rsp_valid_q, rsp_tag_q;
    logic        xfer;
    // On a conflict the pointer hands the grant to the port that did not win last.
    assign i_gnt = reset_n & i_req & (~d_req | last_d_q);
    assign d_gnt = reset_n & d_req & (~i_req | ~last_d_q);
    assign xfer  = i_gnt | d_gnt;
    always_comb begin
        last_d_d = xfer ? d_gnt : last_d_q;
        mode_d   = !xfer ? MODE_IDLE : (d_gnt & d_we) ? MODE_IN : MODE_OUT;
        addr_d   = !xfer ? addr_q : d_gnt ? d_addr : i_addr;
        wdata_d  = !xfer ? wdata_q : d_gnt ? d_wdata : 16'h0000;
        tag_d    = d_gnt;
        cnt_d    = (i_req & d_req & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_d_q    <= 1'b0;
            mode_q      <= MODE_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            last_d_q    <= last_d_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            rsp_valid_q <= mode_q == MODE_OUT;
            rsp_tag_q   <= tag_q;
            cnt_q       <= cnt_d;
        end
    end
    // Masking with reset_n keeps a pending store from reaching the array at the reset edge.
    assign mem_mode     = reset_n ? mode_q : MODE_IDLE;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign i_rvalid     = rsp_valid_q & ~rsp_tag_q;
    assign d_rvalid     = rsp_valid_q & rsp_tag_q;
    assign i_rdata      = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
    localparam logic [1:0] IDLE = 2'b00, RD = 2'b01, WR = 2'b10;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, conflict_cnt;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  mem_mode;
    logic [15:0] mem [0:65535];
    int n_vec = 0, n_err = 0;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_mode == WR) mem[mem_addr] <= mem_wdata;
        if (mem_mode == RD) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_i(input logic [15:0] a);
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b0; i_addr = a;
        #1 check("i_gnt", {31'd0, i_gnt}, 32'd1);
    endtask

    task automatic drive_d(input logic we, input logic [15:0] a, input logic [15:0] w);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w;
        #1 check("d_gnt", {31'd0, d_gnt}, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        #1;
    endtask

    initial begin
        // reset held with both requests high
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
            check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
            check("rst_mode", {30'd0, mem_mode}, {30'd0, IDLE});
            check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1; i_req = 1'b0; d_req = 1'b0;
        // preload through the D port
        drive_d(1'b1, 16'h0010, 16'hBEEF);
        drive_d(1'b1, 16'h0040, 16'hAAAA);
        drive_d(1'b1, 16'h0050, 16'h5555);
        drive_d(1'b1, 16'h0030, 16'h1111);
        check("store_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        idle(); idle();
        check("store_no_rvalid2", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        // single fetch
        drive_i(16'h0010);
        idle();
        check("fetch_early", {31'd0, i_rvalid}, 32'd0);
        idle();
        check("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("fetch_rdata", {16'd0, i_rdata}, 32'h0000BEEF);
        check("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        idle();
        check("fetch_once", {31'd0, i_rvalid}, 32'd0);
        // store then load, same address
        drive_d(1'b1, 16'h0020, 16'h1234);
        drive_d(1'b0, 16'h0020, 16'h0000);
        check("st_mode", {30'd0, mem_mode}, {30'd0, WR});
        idle();
        check("st_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        idle();
        check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("ld_rdata", {16'd0, d_rdata}, 32'h00001234);
        check("ld_i_rvalid", {31'd0, i_rvalid}, 32'd0);
        idle();
        check("ld_once", {31'd0, d_rvalid}, 32'd0);
        // contention right after reset: D wins first, then alternate
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 16'h0040; d_addr = 16'h0050;
        for (int c = 0; c < 10; c++) begin
            int k;
            if (c > 0) @(negedge clk);
            if (c == 6) begin i_req = 1'b0; d_req = 1'b0; end
            #1;
            k = c - 2;
            if (c < 6) begin
                check("cont_i_gnt", {31'd0, i_gnt}, {31'd0, c[0]});
                check("cont_d_gnt", {31'd0, d_gnt}, {31'd0, ~c[0]});
            end
            if (k >= 0 && k < 6) begin
                check("cont_i_rvalid", {31'd0, i_rvalid}, {31'd0, k[0]});
                check("cont_d_rvalid", {31'd0, d_rvalid}, {31'd0, ~k[0]});
                check("cont_rdata", {16'd0, i_rdata}, k[0] ? 32'h0000AAAA : 32'h00005555);
            end else begin
                check("cont_idle_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            end
        end
        check("cont_cnt", {16'd0, conflict_cnt}, 32'd6);
        // reset while a fetch is in flight
        drive_i(16'h0010);
        @(negedge clk);
        reset_n = 1'b0; i_req = 1'b0;
        @(negedge clk);
        #1 check("midrst_rvalid", {31'd0, i_rvalid}, 32'd0);
        reset_n = 1'b1;
        idle();
        check("midrst_rvalid2", {31'd0, i_rvalid}, 32'd0);
        drive_i(16'h0010);
        idle(); idle();
        check("postrst_rvalid", {31'd0, i_rvalid}, 32'd1);
        check("postrst_rdata", {16'd0, i_rdata}, 32'h0000BEEF);
        // store cancelled by reset before the memory samples it
        drive_d(1'b1, 16'h0030, 16'h2222);
        @(negedge clk);
        reset_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_d(1'b0, 16'h0030, 16'h0000);
        idle(); idle();
        check("cancel_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("cancel_rdata", {16'd0, d_rdata}, 32'h00001111);
        // counter saturation
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        repeat (65534) @(negedge clk);
        check("sat_fffe", {16'd0, conflict_cnt}, 32'h0000FFFE);
        @(negedge clk);
        check("sat_ffff", {16'd0, conflict_cnt}, 32'h0000FFFF);
        repeat (5) @(negedge clk);
        check("sat_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);
        i_req = 1'b0; d_req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
